// File: rtl/ds_sinc2_decimator_if.sv
// Bundles the comparator input, enable and conversion result of the sinc2 decimator.
// The master side drives the comparator and enable; the slave side is the decimator.
interface ds_sinc2_decimator_if;
  logic        comp_in;
  logic        enable;
  logic [15:0] data_out;
  logic        data_valid;

  modport master (output comp_in, output enable, input data_out, input data_valid);
  modport slave  (input comp_in, input enable, output data_out, output data_valid);
endinterface

// File: rtl/ds_sinc2_decimator.sv
// Second-order CIC (sinc2) decimator for a 1-bit delta-sigma comparator stream.
// Produces a 16-bit left-justified, saturated result and a one-cycle strobe every OSR cycles.
module ds_sinc2_decimator #(
  parameter int OSR_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  ds_sinc2_decimator_if.slave bus
);
  localparam int W     = 2*OSR_LOG2 + 1;
  localparam int SHIFT = 16 - 2*OSR_LOG2;
  localparam logic [OSR_LOG2-1:0] DEC_LAST = '1;

  logic                sync1;
  logic                b;
  logic [W-1:0]        i1, i2, i2_d, c1_d;
  logic [W-1:0]        c1, c2;
  logic [OSR_LOG2-1:0] dec_cnt;
  logic [1:0]          warm;
  logic                pend;
  logic [15:0]         stage;
  logic [16:0]         r;
  logic [15:0]         sat;
  logic                sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      b     <= 1'b0;
    end else begin
      sync1 <= bus.comp_in;
      b     <= sync1;
    end
  end

  always_comb begin
    sample = bus.enable && (dec_cnt == DEC_LAST);
    c1     = i2 - i2_d;
    c2     = c1 - c1_d;
    r      = 17'(c2) << SHIFT;
    // Only an all-ones input reaches full scale (exactly 65536).
    sat    = r[16] ? 16'hFFFF : r[15:0];
  end

  // A sample result is staged for one cycle, then loaded into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1             <= '0;
      i2             <= '0;
      i2_d           <= '0;
      c1_d           <= '0;
      dec_cnt        <= '0;
      warm           <= '0;
      pend           <= 1'b0;
      stage          <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
    end else if (!bus.enable) begin
      i1             <= '0;
      i2             <= '0;
      i2_d           <= '0;
      c1_d           <= '0;
      dec_cnt        <= '0;
      warm           <= '0;
      pend           <= 1'b0;
      bus.data_valid <= 1'b0;
    end else begin
      i1             <= i1 + {{(W-1){1'b0}}, b};
      i2             <= i2 + i1;
      dec_cnt        <= dec_cnt + OSR_LOG2'(1);
      pend           <= 1'b0;
      bus.data_valid <= pend;
      if (pend) bus.data_out <= stage;
      if (sample) begin
        i2_d <= i2;
        c1_d <= c1;
        if (warm == 2'd2) begin
          pend  <= 1'b1;
          stage <= sat;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end
endmodule

// File: doc/ds_sinc2_decimator.md
Name: ds_sinc2_decimator

Overview:
- Front-end stage of the comparator-based delta-sigma ADC, directly upstream of the pulse-triggered 16-bit serialiser.
- Takes the raw 1-bit comparator output and synchronises it into the clock domain.
- Applies a second-order CIC (sinc2) decimation filter with decimation ratio OSR = 2^OSR_LOG2.
- Produces a 16-bit left-justified conversion result plus a one-cycle strobe; the strobe drives the serialiser trigger directly.

Parameters:
- OSR_LOG2, 8, log2 of the decimation ratio. Legal range 5..8. The 32-cycle minimum output spacing exceeds the serialiser's 17-cycle busy time, so no result is lost.

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- comp_in  input  1  raw comparator output, asynchronous to clk.
- enable  input  1  conversion enable; level-sensitive.
- data_out  output  16  latest conversion result, left-justified and saturated.
- data_valid  output  1  one-cycle pulse when data_out updates; connects to the serialiser trigger.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high; it clears every register. Reset values are data_out = 0x0000 and data_valid = 0.
- Synchroniser: 2-flop chain on comp_in gives bit b, latency 2 cycles. The synchroniser runs whenever rst is low, regardless of enable.
- Width: W = 2*OSR_LOG2 + 1 bits for integrators, comb registers and the comb output.
- Arithmetic wraps modulo 2^W. No wrap handling is required, because the true result always lies in 0..OSR^2 < 2^W.
- Integrators (each enabled cycle):
  - i1 <= i1 + b
  - i2 <= i2 + i1
- Decimation counter dec_cnt:
  - OSR_LOG2 bits, increments each enabled cycle.
  - Wraps from OSR-1 to 0.
  - The cycle where dec_cnt == OSR-1 is the sample cycle.
- Comb (evaluated on the sample cycle, using the i2 value registered at that edge):
  - c1 = i2 - i2_d, then i2_d <= i2
  - c2 = c1 - c1_d, then c1_d <= c1
- Scaling of c2:
  - For OSR_LOG2 < 8: r = c2 << (16 - 2*OSR_LOG2).
  - For OSR_LOG2 = 8: r = c2.
  - If r >= 65536, data_out takes 0xFFFF (saturation occurs only for an all-ones input).
- Warm-up:
  - A 2-bit warm counter suppresses the first two comb outputs after reset or after enable rises.
  - The third and later sample cycles update data_out.
- Output timing:
  - data_out and data_valid are registered on the cycle after the sample cycle.
  - data_valid is high for exactly 1 cycle.
  - data_out holds its value until the next update.
- Steady-state strobe spacing: exactly OSR cycles between data_valid pulses.
- enable low:
  - Synchronously clears i1, i2, i2_d, c1_d, dec_cnt and warm.
  - data_out holds its last value; data_valid = 0.
  - A sample cycle pending at the deassert edge is discarded.
- enable rising: the first data_valid comes 3*OSR enabled cycles plus 1 after the first enabled edge (the +1 is the output register).
- Reset mid-window: everything clears immediately. Any partial result is lost and no strobe is emitted.
- Simultaneous enable fall and sample cycle: the enable clear has priority, so no output is produced.

Test Plan:
- Reset state, OSR_LOG2=5:
  - Stimulus: assert rst with enable=1 and comp_in toggling.
  - Response: data_out = 0x0000 and data_valid = 0 throughout reset.
  - After rst falls, the first data_valid arrives exactly 97 cycles after the first enabled edge, with no earlier pulse.
- All-ones input, OSR_LOG2=5 (gain 1024, shift 6):
  - Stimulus: comp_in = 1 constant.
  - Response: every post-warm-up result is 0xFFFF (saturated).
  - All-zeros input gives 0x0000.
  - With OSR_LOG2=8, all-ones gives 0xFFFF and all-zeros gives 0x0000.
- 50 % duty input, OSR_LOG2=5:
  - Stimulus: comp_in alternating 1/0 each cycle.
  - Response: data_out within 0x8000 ± 0x0400 on every valid after warm-up.
  - data_valid pulses are exactly 32 cycles apart.
- 25 % duty input, OSR_LOG2=8:
  - Stimulus: comp_in pattern 1,0,0,0 repeating.
  - Response: data_out within 0x4000 ± 0x0100.
  - Pulse spacing is 256 cycles.
- Enable gating:
  - Stimulus: deassert enable mid-window (dec_cnt = 17, OSR 32), hold low for 50 cycles, then reassert.
  - Response: no data_valid while low, and data_out holds the old value.
  - The next data_valid arrives 97 cycles after re-enable.
  - Repeat with enable falling exactly on the sample cycle: no strobe.
- Integration with the serialiser:
  - Stimulus: connect data_valid to trigger and data_out to data_in, OSR_LOG2=5, all-ones input.
  - Response: each strobe starts one 16-bit frame.
  - serial_out shows 16 ones per frame with no dropped triggers across 10 frames.
